// File: rtl/sgpio_master.sv
// sgpio_master -- SGPIO initiator (board/BMC side of the serial GPIO link).
//
// Divides i_clk down to the SGPIO clock. For each frame it shifts NBITS of
// i_tx_data out on o_mosi, MSB first. It captures the same number of bits
// from i_miso into o_rx_data. Each bit occupies one SCLK period: CLK_DIV
// cycles low, then CLK_DIV cycles high. o_sync marks the first bit of the
// frame.
//
// Parameters:
//   NBITS      bits per frame (>=2)
//   CLK_DIV    i_clk cycles per SCLK half-period (>=2)
//   GAP_CYCLES idle cycles between automatic frames (>=1)
//
// Ports:
//   i_clk      system clock
//   i_rst      asynchronous reset, active-high
//   i_start    frame request, sampled while o_busy==0
//   i_tx_data  word to send, latched when a start is accepted
//   o_busy     frame in progress
//   o_done     one-cycle pulse; o_rx_data is valid in the same cycle
//   o_rx_data  captured MISO word, held until the next o_done
//   o_sclk     SGPIO clock
//   o_sync     SGPIO frame sync
//   o_mosi     serial data to the slave
//   i_miso     serial data from the slave (asynchronous to i_clk)
//
// Build option: define SGPIO_MASTER_AUTO_EN to ignore i_start. In that mode
// frames run continuously, with GAP_CYCLES idle cycles between them.

module sgpio_master #(
    parameter int NBITS      = 8,
    parameter int CLK_DIV    = 25,
    parameter int GAP_CYCLES = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [NBITS-1:0] i_tx_data,
    output logic             o_busy,
    output logic             o_done,
    output logic [NBITS-1:0] o_rx_data,
    output logic             o_sclk,
    output logic             o_sync,
    output logic             o_mosi,
    input  logic             i_miso
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int BW = $clog2(NBITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(NBITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [BW-1:0]      bit_q, bit_d;
    logic [NBITS-1:0]   tx_q, tx_d;
    logic [NBITS-1:0]   rx_q, rx_d;
    logic [NBITS-1:0]   rx_data_q, rx_data_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               sclk_q, sclk_d;
    logic               sync_q, sync_d;
    logic               mosi_q, mosi_d;
    logic               miso_s1_q, miso_s2_q;
    logic               start_req;

`ifdef SGPIO_MASTER_AUTO_EN
    // Free-running mode: count idle cycles and launch a frame on the last one.
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    logic [GW-1:0] gap_q, gap_d;
    logic          unused_start;

    assign unused_start = i_start;
    assign start_req    = (state_q == IDLE) && (gap_q == GAP_LAST);

    always_comb begin
        gap_d = '0;
        if ((state_q == IDLE) && (gap_q != GAP_LAST)) begin
            gap_d = gap_q + GW'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            gap_q <= '0;
        end else begin
            gap_q <= gap_d;
        end
    end
`else
    localparam int unused_gap_cycles = GAP_CYCLES;

    assign start_req = i_start;
`endif

    // Two-flop synchronizer for the asynchronous slave data.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            miso_s1_q <= 1'b0;
            miso_s2_q <= 1'b0;
        end else begin
            miso_s1_q <= i_miso;
            miso_s2_q <= miso_s1_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        rx_data_d = rx_data_q;

        case (state_q)
            // DONE also accepts a start, so frames can run back-to-back.
            IDLE, DONE: begin
                if (start_req) begin
                    state_d = LOW;
                    cnt_d   = '0;
                    bit_d   = '0;
                    tx_d    = i_tx_data;
                    rx_d    = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            LOW: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = HIGH;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HIGH: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    // Sample at the end of the high phase. MOSI has been stable
                    // for 2*CLK_DIV-1 cycles by then, which covers the
                    // synchronizer delay in loopback.
                    rx_d  = {rx_q[NBITS-2:0], miso_s2_q};
                    if (bit_q == BIT_LAST) begin
                        state_d = DONE;
                    end else begin
                        bit_d   = bit_q + BW'(1);
                        tx_d    = {tx_q[NBITS-2:0], 1'b0};
                        state_d = LOW;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Publish the word on the same edge that raises o_done.
        if (state_d == DONE) begin
            rx_data_d = rx_d;
        end

        // Outputs are derived from the next state so that they are registered
        // and still line up with the state they describe.
        busy_d = (state_d == LOW) || (state_d == HIGH);
        done_d = (state_d == DONE);
        sclk_d = (state_d == HIGH);
        sync_d = busy_d && (bit_d == '0);
        mosi_d = busy_d && tx_d[NBITS-1];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            rx_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sclk_q    <= 1'b0;
            sync_q    <= 1'b0;
            mosi_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            rx_data_q <= rx_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            sclk_q    <= sclk_d;
            sync_q    <= sync_d;
            mosi_q    <= mosi_d;
        end
    end

    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_rx_data = rx_data_q;
    assign o_sclk    = sclk_q;
    assign o_sync    = sync_q;
    assign o_mosi    = mosi_q;

endmodule

// File: tb/tb_sgpio_master.sv
module tb_sgpio_master;

    localparam int NBITS   = 8;
    localparam int CLK_DIV = 4;
    localparam int GAP     = 16;
    localparam int FRAME   = 2 * CLK_DIV * NBITS;

    localparam logic [1:0] MODE_LOOP = 2'd0;
    localparam logic [1:0] MODE_ZERO = 2'd1;
    localparam logic [1:0] MODE_ONE  = 2'd2;

    typedef struct {
        logic [7:0] tx;
        logic [1:0] mode;
        logic [7:0] exp_rx;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] tx_data;
    logic       busy;
    logic       done;
    logic [7:0] rx_data;
    logic       sclk;
    logic       sync;
    logic       mosi;
    logic       miso;
    logic [1:0] miso_mode;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_rx_m;
    vec_t       vecs[6];

    always #5 clk = ~clk;

    assign miso = (miso_mode == MODE_LOOP) ? mosi : miso_mode[1];

    sgpio_master #(
        .NBITS(NBITS),
        .CLK_DIV(CLK_DIV),
        .GAP_CYCLES(GAP)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_start(start),
        .i_tx_data(tx_data),
        .o_busy(busy),
        .o_done(done),
        .o_rx_data(rx_data),
        .o_sclk(sclk),
        .o_sync(sync),
        .o_mosi(mosi),
        .i_miso(miso)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every o_done pops one expected word.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got o_done=1 (rx=0x%02h), expected no frame pending", rx_data);
            end else begin
                exp_rx_m = exp_q.pop_front();
                check("rx_data", {24'd0, rx_data}, {24'd0, exp_rx_m});
            end
        end
    end

    // Called at the negedge where i_start was raised; checks every cycle of the frame.
    task automatic check_frame(input logic [7:0] tx, input int poke_at, input logic [7:0] poke_tx,
                               input bit hold_tail, input logic [7:0] next_tx);
        logic [4:0] exp_v;
        logic [4:0] act_v;
        for (int j = 1; j <= FRAME + 1; j++) begin
            @(negedge clk);
            if (j <= FRAME) begin
                exp_v[4] = 1'b1;
                exp_v[3] = 1'b0;
                exp_v[2] = (((j - 1) % (2 * CLK_DIV)) >= CLK_DIV);
                exp_v[1] = (j <= 2 * CLK_DIV);
                exp_v[0] = tx[NBITS - 1 - (j - 1) / (2 * CLK_DIV)];
            end else begin
                exp_v = 5'b01000;
            end
            act_v = {busy, done, sclk, sync, mosi};
            check($sformatf("frame_%02h_cyc%0d_busy_done_sclk_sync_mosi", tx, j),
                  {27'd0, act_v}, {27'd0, exp_v});
            if (j == 1) start = 1'b0;
            if (poke_at != 0 && j == poke_at) begin
                start   = 1'b1;
                tx_data = poke_tx;
            end
            if (poke_at != 0 && j == poke_at + 1) start = 1'b0;
            if (hold_tail && j >= FRAME) begin
                start   = 1'b1;
                tx_data = next_tx;
            end
        end
    endtask

    initial begin
        vecs[0] = '{8'hA5, MODE_LOOP, 8'hA5};
        vecs[1] = '{8'h00, MODE_ONE,  8'hFF};
        vecs[2] = '{8'h00, MODE_ZERO, 8'h00};
        vecs[3] = '{8'h3C, MODE_LOOP, 8'h3C};
        vecs[4] = '{8'h81, MODE_LOOP, 8'h81};
        vecs[5] = '{8'hFF, MODE_ZERO, 8'h00};

        rst       = 1'b1;
        start     = 1'b0;
        tx_data   = 8'h00;
        miso_mode = MODE_LOOP;
        repeat (3) @(negedge clk);
        check("reset_outputs", {19'd0, busy, done, sclk, sync, mosi, rx_data}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Table of single frames.
        for (int i = 0; i < 6; i++) begin
            miso_mode = vecs[i].mode;
            repeat (4) @(negedge clk);
            exp_q.push_back(vecs[i].exp_rx);
            tx_data = vecs[i].tx;
            start   = 1'b1;
            check_frame(vecs[i].tx, 0, 8'h00, 1'b0, 8'h00);
        end

        // Start mid-frame is ignored; start held through DONE chains a second frame.
        miso_mode = MODE_LOOP;
        repeat (4) @(negedge clk);
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'h69);
        tx_data = 8'h5A;
        start   = 1'b1;
        check_frame(8'h5A, 20, 8'h3C, 1'b1, 8'h69);
        check_frame(8'h69, 0, 8'h00, 1'b0, 8'h00);

        // Reset in the middle of a frame aborts it without o_done.
        repeat (4) @(negedge clk);
        tx_data = 8'hC3;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(negedge clk);
        #2 rst = 1'b1;
        #1 check("async_reset_outputs", {19'd0, busy, done, sclk, sync, mosi, rx_data}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (FRAME + 10) @(negedge clk);
        check("idle_after_reset_busy", {31'd0, busy}, 32'd0);

        exp_q.push_back(8'h96);
        tx_data = 8'h96;
        start   = 1'b1;
        check_frame(8'h96, 0, 8'h00, 1'b0, 8'h00);

        repeat (4) @(negedge clk);
        check("pending_frames", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sgpio_master.md
Name: sgpio_master

Overview:
- SGPIO initiator for the BMC/board side of the serial GPIO link to the FPGA's existing SGPIO slave. Used on the test harness and on carrier logic.
- Divides the system clock to produce the SGPIO clock and frame sync.
- Shifts a parallel word out on MOSI and captures the returned MISO word, one frame per start request.

Parameters:
NBITS, 8, bits per frame (>=2); matches slave user_led/user_sw width
CLK_DIV, 25, i_clk cycles per SGPIO clock half-period (>=2); 50 MHz -> 1 MHz SCLK
GAP_CYCLES, 16, idle i_clk cycles between frames in auto mode (>=1); used only with SGPIO_MASTER_AUTO_EN

Ports:
i_clk  in  1  system clock (clk_sys_50m domain)
i_rst  in  1  asynchronous reset, active-high
i_start  in  1  frame request, sampled when o_busy==0
i_tx_data  in  NBITS  word to send, latched on accepted start
o_busy  out  1  frame in progress
o_done  out  1  one-cycle pulse, o_rx_data valid
o_rx_data  out  NBITS  captured MISO word, held until next o_done
o_sclk  out  1  SGPIO clock
o_sync  out  1  SGPIO frame sync
o_mosi  out  1  serial data to slave
i_miso  in  1  serial data from slave (asynchronous to i_clk)

Behaviour:
- Reset (async, i_rst=1): state IDLE; o_busy, o_done, o_sclk, o_sync, o_mosi, o_rx_data all 0. Shift registers and counters are cleared. Reset mid-frame aborts the frame immediately, and no o_done is produced.
- All outputs are registered.
- Input i_miso passes through a 2-FF synchronizer before use.
- FSM states: IDLE, LOW, HIGH, DONE.
- IDLE:
  - o_sclk=0, o_sync=0, o_mosi=0.
  - On i_start=1: latch i_tx_data into tx shift register, bit index k=0, go to LOW. o_busy=1 from the next cycle.
- LOW (CLK_DIV cycles):
  - o_sclk=0.
  - o_mosi = tx[NBITS-1-k] (MSB first).
  - o_sync=1 only for k==0.
- HIGH (CLK_DIV cycles):
  - o_sclk=1; o_mosi and o_sync hold their LOW-phase values.
  - On the last cycle of HIGH, the synchronized MISO shifts into the rx shift register LSB (MSB-first order).
  - If k==NBITS-1, go to DONE; otherwise k++ and go to LOW.
- DONE (1 cycle):
  - o_rx_data <= rx shift register; o_done=1; o_busy=0.
  - o_sclk=0, o_sync=0, o_mosi=0.
  - An i_start in this cycle is accepted (back-to-back frame); otherwise go to IDLE.
- Latency: o_done is asserted exactly 2*CLK_DIV*NBITS+1 cycles after the accepting i_start cycle.
- i_start while o_busy=1 is ignored and not queued. i_tx_data changes mid-frame have no effect.
- The half-period counter is $clog2(CLK_DIV) wide and wraps to 0 at CLK_DIV-1. The bit index is $clog2(NBITS) wide, with no wrap beyond NBITS-1.
- Direct loopback (o_mosi->i_miso) returns o_rx_data == sent word, because 2-cycle sync delay < 2*CLK_DIV.

Optional Feature:
- Macro: SGPIO_MASTER_AUTO_EN.
- Defined:
  - i_start is ignored.
  - After reset release or after DONE, the block waits GAP_CYCLES i_clk cycles in IDLE, then starts a frame automatically, latching i_tx_data at that cycle.
  - Frames repeat continuously, with o_done pulsing once per frame.
- Not defined: frames run only on i_start, as above.

Test Plan:
- NBITS=8, CLK_DIV=4, loopback o_mosi->i_miso, i_tx_data=0xA5, pulse i_start -> o_mosi carries 1,0,1,0,0,1,0,1 each for 8 cycles; o_done at cycle 65; o_rx_data=0xA5.
- Same frame: check waveforms -> o_sync=1 only during the first 8 cycles; o_sclk is 4 low/4 high, 8 periods total, then 0.
- i_miso tied 1, i_tx_data=0x00 -> o_mosi stays 0, o_rx_data=0xFF. Then i_miso tied 0 -> next frame o_rx_data=0x00.
- i_start pulsed again at cycle 20 mid-frame with i_tx_data=0x3C -> ignored; only one o_done, sent word unchanged; i_start held through the DONE cycle -> second frame begins next cycle.
- i_rst asserted at cycle 30 mid-frame -> all outputs 0 asynchronously, no o_done; a new start after release completes normally with the correct word.
- With SGPIO_MASTER_AUTO_EN and GAP_CYCLES=16 -> o_done pulses every 65+16 cycles, each o_rx_data equal to i_tx_data at that frame's start (loopback).
